jet_infer_scheduler: RTL

Sequencer that feeds the batchnorm jet-tagging inference core from a stream of 16-feature input frames and returns its 5 class scores as a tagged output stream. Buffers frames in a small FIFO, issues a one-cycle launch pulse, waits for completion with a watchdog, and waits a fixed settle delay before capturing results. Sits between the host/DMA-side frame source and the inference core, with one inference in flight at a time.

---
 rtl/jet_infer_scheduler.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/jet_infer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : jet_infer_scheduler
// Brief    : Frame FIFO + launch/wait/settle sequencer for the jet-tagging
//            inference core, returning tagged class scores.
// Revision : 1.0  initial release
// ============================================================================
module jet_infer_scheduler #(
    parameter int WIDTH       = 25,
    parameter int INPUT_SIZE  = 16,
    parameter int OUTPUT_SIZE = 5,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 8,
    parameter int SETTLE      = 4,
    parameter int TIMEOUT     = 4096
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [INPUT_SIZE*WIDTH-1:0]   s_data,
    output logic                          core_input_ready,
    output logic [INPUT_SIZE*WIDTH-1:0]   core_input_data,
    input  logic                          core_output_ready,
    input  logic [OUTPUT_SIZE*WIDTH-1:0]  core_output_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [OUTPUT_SIZE*WIDTH-1:0]  m_data,
    output logic [TAG_W-1:0]              m_tag,
    output logic                          m_error,
    output logic                          busy
);
    localparam int c_IW   = INPUT_SIZE * WIDTH;
    localparam int c_OW   = OUTPUT_SIZE * WIDTH;
    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_PW   = c_AW + 1;
    localparam int c_WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_ST_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_ST_W-1:0] c_ST_LAST = c_ST_W'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_IW-1:0]     r_mem [DEPTH];
    logic [c_PW-1:0]     r_wr_ptr;
    logic [c_PW-1:0]     r_rd_ptr;
    logic [TAG_W-1:0]    r_tag_cnt;
    logic [TAG_W-1:0]    r_flight_tag;
    logic [c_WD_W-1:0]   r_wd_cnt;
    logic [c_ST_W-1:0]   r_st_cnt;
    logic                r_cor_q;
    logic                r_cir;
    logic [c_IW-1:0]     r_cid;
    logic                r_m_valid;
    logic [c_OW-1:0]     r_m_data;
    logic [TAG_W-1:0]    r_m_tag;
    logic                r_m_error;

    logic w_empty, w_full, w_push, w_pop, w_edge, w_out_free;

    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                        (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_push     = s_valid && !w_full;
    assign w_pop      = (r_state == S_LAUNCH);
    assign w_edge     = core_output_ready && !r_cor_q;
    assign w_out_free = !r_m_valid || m_ready;

    assign s_ready          = !w_full;
    assign core_input_ready = r_cir;
    assign core_input_data  = r_cid;
    assign m_valid          = r_m_valid;
    assign m_data           = r_m_data;
    assign m_tag            = r_m_tag;
    assign m_error          = r_m_error;
    assign busy             = (r_state != S_IDLE) || !w_empty;

    // Frame storage carries no reset; only the pointers define occupancy.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_tag_cnt    <= '0;
            r_flight_tag <= '0;
            r_wd_cnt     <= '0;
            r_st_cnt     <= '0;
            r_cor_q      <= 1'b0;
            r_cir        <= 1'b0;
            r_cid        <= '0;
            r_m_valid    <= 1'b0;
            r_m_data     <= '0;
            r_m_tag      <= '0;
            r_m_error    <= 1'b0;
        end else begin
            r_cor_q <= core_output_ready;
            r_cir   <= 1'b0;
            if (r_m_valid && m_ready) r_m_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_empty && w_out_free) begin
                        r_state      <= S_LAUNCH;
                        r_cir        <= 1'b1;
                        r_cid        <= r_mem[r_rd_ptr[c_AW-1:0]];
                        r_flight_tag <= r_tag_cnt;
                    end
                end
                S_LAUNCH: begin
                    // A completion edge coinciding with the launch exit already counts.
                    r_tag_cnt <= r_tag_cnt + TAG_W'(1);
                    r_wd_cnt  <= '0;
                    r_st_cnt  <= '0;
                    r_state   <= w_edge ? S_SETTLE : S_WAIT;
                end
                S_WAIT: begin
                    if (w_edge) begin
                        r_st_cnt <= '0;
                        r_state  <= S_SETTLE;
                    end else if ((TIMEOUT != 0) && (r_wd_cnt == c_WD_LAST)) begin
                        r_m_valid <= 1'b1;
                        r_m_error <= 1'b1;
                        r_m_data  <= '0;
                        r_m_tag   <= r_flight_tag;
                        r_state   <= S_IDLE;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + c_WD_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (r_st_cnt == c_ST_LAST) begin
                        r_m_valid <= 1'b1;
                        r_m_error <= 1'b0;
                        r_m_data  <= core_output_data;
                        r_m_tag   <= r_flight_tag;
                        r_state   <= S_IDLE;
                    end else begin
                        r_st_cnt <= r_st_cnt + c_ST_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
